hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Detects load-use hazards, handles instruction-memory misses and
// mispredict redirects, and keeps saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_mispredict,
  input  logic                  imem_ready,
  input  logic                  stats_clear,
  output logic                  pc_write,
  output logic                  redirect_sel,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            state,
  output logic [DATA_WIDTH-1:0] stall_cnt,
  output logic [DATA_WIDTH-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [3:0]            FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE    = DATA_WIDTH'(1);

  logic [1:0] state_d;
  logic [3:0] fcnt_q;
  logic [3:0] fcnt_d;
  logic       load_use;

  // Load in EX whose destination feeds a source the ID instruction reads.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  // Output decode and next-state selection; mispredict overrides every state.
  always_comb begin
    pc_write     = 1'b1;
    redirect_sel = 1'b0;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    state_d      = state;
    fcnt_d       = fcnt_q;

    if (ex_mispredict) begin
      pc_write     = 1'b1;
      redirect_sel = 1'b1;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FLUSH_LOAD;
      end else begin
        state_d = imem_ready ? ST_RUN : ST_MISS;
        fcnt_d  = '0;
      end
    end else begin
      case (state)
        ST_MISS: begin
          if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = imem_ready ? ST_RUN : ST_MISS;
          end else if (!imem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            state_d    = ST_MISS;
          end else begin
            state_d    = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // ID holds a squashed instruction here, so load-use is irrelevant.
          pc_write   = imem_ready;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          // The mispredict cycle itself is the first flush cycle; leaving when
          // the count reaches zero gives FLUSH_CYCLES flush cycles in total.
          fcnt_d = (fcnt_q == 4'd0) ? 4'd0 : (fcnt_q - 4'd1);
          if (fcnt_q <= 4'd1) begin
            state_d = imem_ready ? ST_RUN : ST_MISS;
          end
        end
        default: begin
          if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = ST_RUN;
          end else if (!imem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            state_d    = ST_MISS;
          end else begin
            state_d    = ST_RUN;
          end
        end
      endcase
    end
  end

  // State and flush down-counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_RUN;
      fcnt_q <= '0;
    end else begin
      state  <= state_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (stats_clear) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (ifid_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl with narrow
// counters (saturation reachable) and a three-cycle flush.
module tb_hazard_ctrl;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [4:0]    id_rs1 = '0;
  logic [4:0]    id_rs2 = '0;
  logic          id_uses_rs1 = 1'b0;
  logic          id_uses_rs2 = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic [4:0]    ex_rd = '0;
  logic          ex_mispredict = 1'b0;
  logic          imem_ready = 1'b1;
  logic          stats_clear = 1'b0;
  logic          pc_write;
  logic          redirect_sel;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_flush;
  logic [1:0]    state;
  logic [DW-1:0] stall_cnt;
  logic [DW-1:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.DATA_WIDTH(DW), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_mispredict(ex_mispredict), .imem_ready(imem_ready),
    .stats_clear(stats_clear),
    .pc_write(pc_write), .redirect_sel(redirect_sel),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_mispredict = 1'b0;
    imem_ready = 1'b1; stats_clear = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic clr();
    idle();
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("clr_stall", 32'(stall_cnt), 0);
    chk("clr_flush", 32'(flush_cnt), 0);
  endtask

  // Structural invariants sampled mid-cycle while out of reset.
  always @(negedge clk) begin
    if (rstn) begin
      chk("inv_ifid_excl", 32'(ifid_write & ifid_flush), 0);
      chk("inv_redir_pc", 32'(redirect_sel & ~pc_write), 0);
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    // Reset state and RUN decoding during reset
    #1 rstn = 1'b0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    chk("rst_pcw", 32'(pc_write), 1);
    imem_ready = 1'b0;
    #1;
    chk("rst_miss_pcw", 32'(pc_write), 0);
    chk("rst_miss_flush", 32'(ifid_flush), 1);
    chk("rst_miss_state", 32'(state), 0);
    imem_ready = 1'b1;
    #4 rstn = 1'b1;
    tick();

    // Load-use on rs1
    clr();
    set_load_use();
    #2;
    chk("lu_pcw", 32'(pc_write), 0);
    chk("lu_ifidw", 32'(ifid_write), 0);
    chk("lu_idex", 32'(idex_flush), 1);
    chk("lu_ifidf", 32'(ifid_flush), 0);
    tick();
    chk("lu_state", 32'(state), 0);
    chk("lu_stall", 32'(stall_cnt), 1);
    chk("lu_flushc", 32'(flush_cnt), 0);

    // Load-use on rs2 only
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #2;
    chk("lu2_idex", 32'(idex_flush), 1);
    chk("lu2_pcw", 32'(pc_write), 0);
    tick();
    chk("lu2_stall", 32'(stall_cnt), 2);

    // Matching register but source not used
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
    #2;
    chk("nouse_pcw", 32'(pc_write), 1);
    chk("nouse_idex", 32'(idex_flush), 0);
    tick();

    // ex_rd = x0 never stalls
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #2;
    chk("x0_pcw", 32'(pc_write), 1);
    chk("x0_ifidw", 32'(ifid_write), 1);
    chk("x0_idex", 32'(idex_flush), 0);
    tick();
    chk("x0_stall", 32'(stall_cnt), 2);

    // Three-cycle imem miss from RUN
    clr();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      #2;
      chk("miss_pcw", 32'(pc_write), 0);
      chk("miss_ifidf", 32'(ifid_flush), 1);
      chk("miss_ifidw", 32'(ifid_write), 0);
      tick();
      chk("miss_state", 32'(state), 1);
    end
    imem_ready = 1'b1;
    #2;
    chk("miss_rdy_pcw", 32'(pc_write), 1);
    chk("miss_rdy_ifidw", 32'(ifid_write), 1);
    chk("miss_rdy_ifidf", 32'(ifid_flush), 0);
    tick();
    chk("miss_end_state", 32'(state), 0);
    chk("miss_stall", 32'(stall_cnt), 3);
    chk("miss_flushc", 32'(flush_cnt), 3);

    // Mispredict pulse, flush of three cycles in total
    clr();
    ex_mispredict = 1'b1;
    #2;
    chk("mp_redir", 32'(redirect_sel), 1);
    chk("mp_pcw", 32'(pc_write), 1);
    chk("mp_ifidf", 32'(ifid_flush), 1);
    chk("mp_idex", 32'(idex_flush), 1);
    chk("mp_ifidw", 32'(ifid_write), 0);
    tick();
    chk("mp_state1", 32'(state), 2);
    ex_mispredict = 1'b0;
    #2;
    chk("fl1_redir", 32'(redirect_sel), 0);
    chk("fl1_ifidf", 32'(ifid_flush), 1);
    chk("fl1_pcw", 32'(pc_write), 1);
    chk("fl1_idex", 32'(idex_flush), 0);
    tick();
    chk("mp_state2", 32'(state), 2);
    #2;
    chk("fl2_ifidf", 32'(ifid_flush), 1);
    tick();
    chk("mp_state3", 32'(state), 0);
    #2;
    chk("fl_done_ifidf", 32'(ifid_flush), 0);
    chk("fl_done_pcw", 32'(pc_write), 1);
    chk("mp_flushc", 32'(flush_cnt), 3);
    chk("mp_stall", 32'(stall_cnt), 0);
    tick();

    // Flush with imem not ready exits to MISS
    ex_mispredict = 1'b1;
    tick();
    ex_mispredict = 1'b0;
    imem_ready = 1'b0;
    #2;
    chk("flnr_pcw", 32'(pc_write), 0);
    tick();
    chk("flnr_state1", 32'(state), 2);
    tick();
    chk("flnr_state2", 32'(state), 1);
    imem_ready = 1'b1;
    tick();
    chk("flnr_state3", 32'(state), 0);

    // Second mispredict inside FLUSH reloads the counter
    ex_mispredict = 1'b1;
    tick();
    #2;
    chk("rl_redir", 32'(redirect_sel), 1);
    tick();
    ex_mispredict = 1'b0;
    chk("rl_state1", 32'(state), 2);
    tick();
    chk("rl_state2", 32'(state), 2);
    tick();
    chk("rl_state3", 32'(state), 0);

    // Mispredict in MISS with concurrent load-use
    idle();
    imem_ready = 1'b0;
    tick();
    chk("mm_state", 32'(state), 1);
    set_load_use();
    ex_mispredict = 1'b1;
    #2;
    chk("mm_redir", 32'(redirect_sel), 1);
    chk("mm_pcw", 32'(pc_write), 1);
    chk("mm_ifidf", 32'(ifid_flush), 1);
    chk("mm_idex", 32'(idex_flush), 1);
    chk("mm_ifidw", 32'(ifid_write), 0);
    tick();
    chk("mm_state2", 32'(state), 2);
    idle();
    tick();
    tick();
    chk("mm_state3", 32'(state), 0);

    // Stall counter saturation and clear-over-increment
    clr();
    set_load_use();
    for (int i = 0; i < 15; i++) tick();
    chk("sat_full", 32'(stall_cnt), 15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 15);
    chk("sat_flushc", 32'(flush_cnt), 0);
    stats_clear = 1'b1;
    tick();
    chk("clr_vs_inc", 32'(stall_cnt), 0);
    stats_clear = 1'b0;

    // Flush counter saturation via a long miss
    idle();
    imem_ready = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("fsat_flush", 32'(flush_cnt), 15);
    chk("fsat_stall", 32'(stall_cnt), 15);
    chk("fsat_state", 32'(state), 1);
    imem_ready = 1'b1;
    tick();

    // Asynchronous reset in the middle of FLUSH
    ex_mispredict = 1'b1;
    tick();
    ex_mispredict = 1'b0;
    chk("ar_pre_state", 32'(state), 2);
    #2 rstn = 1'b0;
    #1;
    chk("ar_state", 32'(state), 0);
    chk("ar_stall", 32'(stall_cnt), 0);
    chk("ar_flush", 32'(flush_cnt), 0);
    chk("ar_ifidf", 32'(ifid_flush), 0);
    #2 rstn = 1'b1;
    tick();
    #2;
    chk("ar_post_ifidf", 32'(ifid_flush), 0);
    chk("ar_post_pcw", 32'(pc_write), 1);
    tick();
    chk("ar_post_state", 32'(state), 0);
    chk("ar_post_flushc", 32'(flush_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
